pulse_period_meter_mc: RTL and testbench

Multi-channel successor to the single-channel pulse edge counter. Each of CH_NUM asynchronous pulse inputs is synchronised and edge-detected, using a selectable edge mode. The block measures the clock-cycle period between consecutive qualifying edges, with saturation and an overflow flag. Completed measurements are buffered per channel and merged onto a single valid/ready output stream by a round-robin arbiter for downstream capture logic.

---
 rtl/pulse_period_meter_mc.sv | 158 +++++++++++++++
 tb/tb_pulse_period_meter_mc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter_mc.sv
// Multi-channel pulse period meter: measures clock cycles between qualifying edges per channel.
// Latency: an edge seen in cycle t presents on o_vld at t+2 when the output register is free.
// Backpressure: output holds while o_vld & ~i_rdy; one pending slot per channel, newest wins (sticky o_overrun).
//
// Ports: i_clk, i_rst_n (sync, active-low), i_pulse/i_en (per channel), i_edge_mode (00 rise,
// 01 fall, 10 both, 11 rise), o_vld/i_rdy handshake carrying o_ch, o_period, o_ovf; o_overrun sticky.
module pulse_period_meter_mc #(
    parameter int CH_NUM      = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CH_NUM-1:0] i_pulse,
    input  logic [CH_NUM-1:0] i_en,
    input  logic [1:0]        i_edge_mode,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [CH_W-1:0]   o_ch,
    output logic [CNT_W-1:0]  o_period,
    output logic              o_ovf,
    output logic [CH_NUM-1:0] o_overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CH_NUM-1:0] sync_q [SYNC_STAGES];
    logic [CH_NUM-1:0] hist_q;
    logic [CNT_W-1:0]  cnt_q [CH_NUM];
    logic [CH_NUM-1:0] cnt_ovf_q;
    logic [CH_NUM-1:0] armed_q;
    logic [CH_NUM-1:0] pend_q;
    logic [CNT_W-1:0]  pend_per_q [CH_NUM];
    logic [CH_NUM-1:0] pend_ovf_q;
    logic [CH_W-1:0]   ptr_q;

    logic [CH_NUM-1:0] sync_out;
    logic [CH_NUM-1:0] edge_hit;
    logic [CH_NUM-1:0] meas;
    logic [CH_NUM-1:0] xfer;
    logic              out_free;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W:0]     scan_idx;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign out_free = ~o_vld | i_rdy;

    // Edge qualification compares the synchroniser output against one more flop of history.
    always_comb begin
        edge_hit = '0;
        case (i_edge_mode)
            2'b01:   edge_hit = ~sync_out & hist_q;
            2'b10:   edge_hit = sync_out ^ hist_q;
            default: edge_hit = sync_out & ~hist_q;
        endcase
        edge_hit = edge_hit & i_en;
        meas     = edge_hit & armed_q;
    end

    // Round-robin: scan starting one past the last granted channel, wrapping at CH_NUM.
    // scan_idx is one bit wider than CH_W so ptr+i never overflows before the wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            scan_idx = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (scan_idx >= (CH_W+1)'(CH_NUM)) begin
                scan_idx = scan_idx - (CH_W+1)'(CH_NUM);
            end
            if (!gnt_found && pend_q[scan_idx[CH_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[CH_W-1:0];
            end
        end
        xfer = '0;
        if (out_free && gnt_found) begin
            xfer[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q     <= '0;
            cnt_ovf_q  <= '0;
            armed_q    <= '0;
            pend_q     <= '0;
            pend_ovf_q <= '0;
            o_overrun  <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                cnt_q[k]      <= '0;
                pend_per_q[k] <= '0;
            end
            ptr_q    <= CH_W'(CH_NUM - 1);
            o_vld    <= 1'b0;
            o_ch     <= '0;
            o_period <= '0;
            o_ovf    <= 1'b0;
        end else begin
            sync_q[0] <= i_pulse;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_out;

            for (int k = 0; k < CH_NUM; k++) begin
                if (!i_en[k]) begin
                    cnt_q[k]     <= '0;
                    cnt_ovf_q[k] <= 1'b0;
                    armed_q[k]   <= 1'b0;
                    pend_q[k]    <= 1'b0;
                    o_overrun[k] <= 1'b0;
                end else begin
                    // Counter restarts at 1 so the value sampled at the next edge equals the distance.
                    if (edge_hit[k]) begin
                        cnt_q[k]     <= {{(CNT_W-1){1'b0}}, 1'b1};
                        cnt_ovf_q[k] <= 1'b0;
                        armed_q[k]   <= 1'b1;
                    end else if (cnt_q[k] == CNT_MAX) begin
                        cnt_ovf_q[k] <= 1'b1;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + 1'b1;
                    end

                    // A measurement coinciding with a transfer refills the slot; that is not an overrun.
                    if (meas[k]) begin
                        pend_q[k]     <= 1'b1;
                        pend_per_q[k] <= cnt_q[k];
                        pend_ovf_q[k] <= cnt_ovf_q[k];
                        if (pend_q[k] && !xfer[k]) begin
                            o_overrun[k] <= 1'b1;
                        end
                    end else if (xfer[k]) begin
                        pend_q[k] <= 1'b0;
                    end
                end
            end

            if (out_free) begin
                if (gnt_found) begin
                    o_vld    <= 1'b1;
                    o_ch     <= gnt_idx;
                    o_period <= pend_per_q[gnt_idx];
                    o_ovf    <= pend_ovf_q[gnt_idx];
                    ptr_q    <= gnt_idx;
                end else begin
                    o_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_period_meter_mc.sv
// Bench for pulse_period_meter_mc: directed scenarios followed by randomized pulses,
// compared every cycle against a timestamp-based reference model (periods are edge-time differences).
module tb_pulse_period_meter_mc;

    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int SS   = 2;
    localparam int CHW  = 2;
    localparam int PMAX = (1 << CW) - 1;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic [CH-1:0]   i_pulse;
    logic [CH-1:0]   i_en;
    logic [1:0]      i_edge_mode;
    logic            o_vld;
    logic            i_rdy;
    logic [CHW-1:0]  o_ch;
    logic [CW-1:0]   o_period;
    logic            o_ovf;
    logic [CH-1:0]   o_overrun;

    pulse_period_meter_mc #(.CH_NUM(CH), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pulse     (i_pulse),
        .i_en        (i_en),
        .i_edge_mode (i_edge_mode),
        .o_vld       (o_vld),
        .i_rdy       (i_rdy),
        .o_ch        (o_ch),
        .o_period    (o_period),
        .o_ovf       (o_ovf),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    // pv[c] = pulse vector driven during cycle c
    logic [CH-1:0] pv[$];

    // reference model state
    logic [CH-1:0] m_arm, m_pend, m_po, m_ovr;
    int            m_pd   [CH];
    int            m_last [CH];
    int            m_ptr;
    logic          m_vld, m_ovf, m_dchk;
    int            m_ch, m_per;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, t, act, exp);
        end
    endtask

    function automatic logic [CH-1:0] pv_at(int i);
        if (i < 0 || i >= pv.size()) return '0;
        return pv[i];
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [CH-1:0] s, h, hit;
        bit   free, found, meas, xf;
        int   g, d, c;
        pv.push_back(i_pulse);
        if (!i_rst_n) begin
            // synchroniser and history flops clear: the last SS+1 samples are effectively zero
            for (int i = t - SS; i <= t; i++) if (i >= 0) pv[i] = '0;
            m_arm = '0; m_pend = '0; m_po = '0; m_ovr = '0;
            for (int k = 0; k < CH; k++) begin m_pd[k] = 0; m_last[k] = 0; end
            m_ptr = CH - 1; m_vld = 0; m_ch = 0; m_per = 0; m_ovf = 0; m_dchk = 1;
            return;
        end
        s = pv_at(t - SS);
        h = pv_at(t - SS - 1);
        case (i_edge_mode)
            2'b01:   hit = h & ~s;
            2'b10:   hit = h ^ s;
            default: hit = s & ~h;
        endcase
        free  = !m_vld || i_rdy;
        found = 0;
        g     = 0;
        if (free) begin
            for (int i = 1; i <= CH; i++) begin
                c = (m_ptr + i) % CH;
                if (!found && m_pend[c]) begin found = 1; g = c; end
            end
            if (found) begin
                m_vld = 1; m_ch = g; m_per = m_pd[g]; m_ovf = m_po[g]; m_ptr = g; m_dchk = 0;
            end else begin
                m_vld = 0;
            end
        end
        for (int k = 0; k < CH; k++) begin
            if (!i_en[k]) begin
                m_arm[k] = 0; m_pend[k] = 0; m_ovr[k] = 0;
            end else begin
                meas = hit[k] && m_arm[k];
                xf   = found && (g == k);
                if (meas) begin
                    d = t - m_last[k];
                    if (m_pend[k] && !xf) m_ovr[k] = 1;
                    m_pend[k] = 1;
                    m_pd[k]   = (d > PMAX) ? PMAX : d;
                    m_po[k]   = (d > PMAX);
                end else if (xf) begin
                    m_pend[k] = 0;
                end
                if (hit[k]) begin m_arm[k] = 1; m_last[k] = t; end
            end
        end
    endtask

    task automatic compare();
        check("vld", 32'(o_vld), 32'(m_vld));
        check("overrun", 32'(o_overrun), 32'(m_ovr));
        if (m_vld || m_dchk) begin
            check("ch", 32'(o_ch), 32'(m_ch));
            check("period", 32'(o_period), 32'(m_per));
            check("ovf", 32'(o_ovf), 32'(m_ovf));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge i_clk);
        #1;
        t++;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // one-cycle high pulse on channel k, then low for gap-1 cycles
    task automatic pulse1(input int k, input int gap);
        i_pulse[k] = 1'b1;
        cycle();
        i_pulse[k] = 1'b0;
        run(gap - 1);
    endtask

    initial begin
        int hold [CH];
        i_rst_n = 0; i_pulse = '0; i_en = '0; i_edge_mode = 2'b00; i_rdy = 1'b1;
        run(4);
        i_rst_n = 1;
        run(2);

        // basic: ch0 rising, 10-cycle period
        i_en = 4'b0001;
        repeat (8) pulse1(0, 10);
        run(5);

        // both edges on ch1: 3 high / 7 low
        i_en = 4'b0010; i_edge_mode = 2'b10;
        repeat (6) begin
            i_pulse[1] = 1'b1; run(3);
            i_pulse[1] = 1'b0; run(7);
        end
        run(5);
        // saturation then recovery
        i_edge_mode = 2'b00;
        repeat (3) pulse1(1, 300);
        repeat (3) pulse1(1, 10);
        run(5);

        // arbitration: simultaneous edges from pointer reset order, then after ch2 alone
        i_en = 4'hf;
        repeat (3) begin
            i_pulse = 4'hf; cycle(); i_pulse = '0; run(19);
        end
        pulse1(2, 10);
        i_pulse = 4'hf; cycle(); i_pulse = '0; run(10);

        // backpressure and overrun on ch2
        i_en = '0; cycle();
        i_en = 4'b0100; i_rdy = 1'b0;
        pulse1(2, 10);
        pulse1(2, 12);
        pulse1(2, 14);
        pulse1(2, 6);
        i_rdy = 1'b1; run(6);
        i_en[2] = 1'b0; run(3);

        // enable drop mid-period on ch0
        i_en = 4'b0001;
        pulse1(0, 10);
        pulse1(0, 4);
        i_en[0] = 1'b0; run(3);
        i_en[0] = 1'b1; run(5);
        repeat (4) pulse1(0, 11);

        // reset while output held and pends set
        i_en = 4'hf; i_rdy = 1'b0;
        repeat (3) begin
            i_pulse = 4'hf; cycle(); i_pulse = '0; run(7);
        end
        i_pulse = 4'b0101;
        i_rst_n = 1'b0; cycle();
        i_rst_n = 1'b1; i_pulse = '0; i_rdy = 1'b1; run(20);

        // randomized traffic
        for (int k = 0; k < CH; k++) hold[k] = 1;
        for (int blk = 0; blk < 4; blk++) begin
            i_edge_mode = 2'($urandom_range(0, 3));
            for (int n = 0; n < 900; n++) begin
                for (int k = 0; k < CH; k++) begin
                    if (hold[k] == 0) begin
                        i_pulse[k] = ~i_pulse[k];
                        hold[k] = ($urandom_range(0, 24) == 0) ? int'($urandom_range(250, 320))
                                                                : int'($urandom_range(0, 14));
                    end else begin
                        hold[k]--;
                    end
                    if ($urandom_range(0, 399) == 0) i_en[k] = ~i_en[k];
                end
                i_rdy = ($urandom_range(0, 9) < 7);
                cycle();
            end
        end
        i_rst_n = 1'b0; cycle();
        i_rst_n = 1'b1; i_pulse = '0; run(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
